sd_read_sched: RTL and testbench
================================

# sd_read_sched

Block-read scheduler in front of the SPI-mode SD card reader. It shares the reader between two requesters: the background-music stream, which refills the audio FIFO from a looping block range, and the asset loader, which fetches N consecutive blocks for maps and sprites. It issues `rd` and the block address to the reader and tracks reader progress through its 5-bit state code. It reports which requester owns the block currently streaming into the FIFO.

## Interface
Parameters:
- `SD_IDLE_CODE`, 6: reader state code meaning "idle, ready for `rd`".
- `LOW_WATER`, 1024: music becomes eligible when `fifo_usedw < LOW_WATER` (16-bit words).
- `URGENT_WATER`, 256: below this, music wins arbitration unconditionally.
- `TIMEOUT_CYCLES`, 2_000_000: watchdog limit per block (only with `SD_SCHED_WATCHDOG_EN`).

Ports:
- `clk` in 1: system clock, same clock as the reader.
- `reset_n` in 1: asynchronous, active-low reset.
- `sd_status` in 5: reader state code.
- `sd_rd` out 1: read request to the reader.
- `sd_address` out 32: byte address of the block (multiple of 512).
- `sd_reset` out 1: reader reset pulse, driven by the watchdog.
- `fifo_usedw` in 11: audio FIFO fill level.
- `mus_en` in 1: music streaming enabled.
- `mus_start` in 32: first block address of the music loop.
- `mus_end` in 32: last block address of the music loop.
- `mus_restart` in 1: one-cycle pulse that rewinds the music pointer to `mus_start`.
- `ld_req` in 1: one-cycle pulse that starts a loader job.
- `ld_addr` in 32: first block address of the loader job.
- `ld_blocks` in 16: number of blocks in the loader job.
- `ld_busy` out 1: loader job in progress.
- `ld_done` out 1: one-cycle pulse when the loader job completes.
- `grant` out 1: owner of the current or most recent block (0 = music, 1 = loader).
- `err` out 1: sticky watchdog error flag.

## Operation
- Reset values:
  - `sd_rd`=0, `sd_address`=0, `sd_reset`=0, `grant`=0, `ld_busy`=0, `ld_done`=0, `err`=0.
  - Music pointer=0, loader count=0.
  - State=WAIT_READY.
- States:
  - WAIT_READY: stay until `sd_status==SD_IDLE_CODE`, which covers card boot and initialisation. Then go to ARB.
  - ARB: evaluate eligibility and pick a requester.
    - Music is eligible if `mus_en && fifo_usedw<LOW_WATER`.
    - Loader is eligible if `ld_busy`.
    - Only one eligible: grant it.
    - Both eligible: music wins if `fifo_usedw<URGENT_WATER`; otherwise the requester not granted last time wins (round-robin).
    - On a grant, load `sd_address` (music pointer or loader pointer), set `grant`, and go to ISSUE. With nothing eligible, stay in ARB.
  - ISSUE: hold `sd_rd`=1. When `sd_status!=SD_IDLE_CODE`, drop `sd_rd` and go to BUSY.
  - BUSY: wait for `sd_status==SD_IDLE_CODE`, meaning the block and CRC are consumed. Then go to DONE.
  - DONE (one cycle): advance the owner's pointer, then return to ARB.
    - Music: if pointer==`mus_end`, reload `mus_start`; else add 512.
    - Loader: add 512 to the address and decrement the count. If the count reaches 0, clear `ld_busy` and pulse `ld_done`.
- Loader accept:
  - `ld_req` with `!ld_busy` latches `ld_addr`/`ld_blocks` and sets `ld_busy`.
  - `ld_req` while `ld_busy` is ignored.
  - `ld_blocks==0` gives no reads and an `ld_done` pulse the next cycle, with `ld_busy` never set.
- `mus_restart`:
  - Outside a music block: the pointer is set to `mus_start` immediately.
  - During a music block (ISSUE/BUSY/DONE with `grant`=0): the in-flight block completes, and the pointer is set to `mus_start` instead of advancing.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. `mus_end` is compared for equality only. If `mus_end<mus_start`, the stream runs to the 2^32 wrap; that is the user's responsibility.
- `mus_en` falling mid-block does not abort the block.

## Timing
- All outputs are registered.
- `sd_rd` rises the cycle after the ARB decision. It falls the cycle after the first cycle with `sd_status!=SD_IDLE_CODE`.
- `sd_address` and `grant` are stable from the ARB decision until the next ARB decision.
- ARB-to-ARB overhead is 3 cycles plus the reader time (ARB, ISSUE≥1, DONE).
- `ld_done` is high exactly 1 cycle, in the cycle after DONE.
- Asserting `reset_n` low at any time forces reset values asynchronously. The in-flight block is abandoned and loader state is lost.

## Configuration
- `SD_SCHED_WATCHDOG_EN` defined:
  - A cycle counter runs in ISSUE/BUSY and is cleared on entering ISSUE.
  - When it reaches `TIMEOUT_CYCLES`:
    - `sd_reset`=1 for 4 cycles and `err` is set (sticky until `reset_n`).
    - The state goes to WAIT_READY.
    - Pointers do not advance, so the same block is retried.
- Undefined: no counter; `sd_reset` and `err` are tied to 0.

## Test plan
- Music refill: `mus_en`=1, `mus_start`=0x1000, `mus_end`=0x1400, `fifo_usedw`=100, with a reader model → `sd_address` sequence 0x1000, 0x1200, 0x1400, 0x1000; `grant`=0 throughout.
- Loader only: `mus_en`=0, `ld_req` with `ld_addr`=0x8000, `ld_blocks`=3 → addresses 0x8000, 0x8200, 0x8400. `ld_busy` is high through all three blocks. `ld_done` is a single-cycle pulse after the third block returns to idle.
- Arbitration:
  - Both eligible with `fifo_usedw`=600 → grants alternate music/loader.
  - With `fifo_usedw`=100 → music is granted every time until usedw≥256.
- Edge cases:
  - `ld_blocks`=0 → `ld_done` pulse next cycle, no `sd_rd`.
  - `ld_req` while busy → ignored; the original job count is unchanged.
- `mus_restart` during a music BUSY at pointer 0x1200 → the block completes and the next music address is 0x1000. Separately, `reset_n` low mid-BUSY → all outputs return to reset values immediately.
- Watchdog (`SD_SCHED_WATCHDOG_EN`, `TIMEOUT_CYCLES`=1000): reader stuck non-idle → `sd_reset` high 4 cycles at cycle 1000 and `err`=1. After the reader returns to idle, the same address is reissued.

Source files
------------

// File: rtl/sd_read_sched.sv
// Arbitrates SD block reads between music refill and asset loader; ARB->ISSUE->BUSY->DONE, 3 cycles + reader time.
// Backpressure via reader state code (waits for idle); optional watchdog under `SD_SCHED_WATCHDOG_EN`.
module sd_read_sched #(
   parameter SD_IDLE_CODE   = 6,
   parameter LOW_WATER      = 1024,
   parameter URGENT_WATER   = 256,
   parameter TIMEOUT_CYCLES = 2_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  sd_status,
   output logic        sd_rd,
   output logic [31:0] sd_address,
   output logic        sd_reset,
   input  logic [10:0] fifo_usedw,
   input  logic        mus_en,
   input  logic [31:0] mus_start,
   input  logic [31:0] mus_end,
   input  logic        mus_restart,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [15:0] ld_blocks,
   output logic        ld_busy,
   output logic        ld_done,
   output logic        grant,
   output logic        err
);

   localparam logic [2:0] ST_WAIT  = 3'd0;
   localparam logic [2:0] ST_ARB   = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_BUSY  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [4:0] IDLE     = 5'(SD_IDLE_CODE);

   logic [2:0]  state;
   logic [31:0] mus_ptr;
   logic [31:0] ld_ptr;
   logic [15:0] ld_cnt;
   logic        restart_pend;
   logic        wd_fire;

   logic sd_idle, mus_elig, urgent, pick_ld, mus_block;
   assign sd_idle   = (sd_status == IDLE);
   assign mus_elig  = mus_en && ({21'd0, fifo_usedw} < 32'(LOW_WATER));
   assign urgent    = ({21'd0, fifo_usedw} < 32'(URGENT_WATER));
   // Loader takes the slot when music is absent, or on a non-urgent tie if music went last.
   assign pick_ld   = ld_busy && (!mus_elig || (!urgent && !grant));
   assign mus_block = !grant && (state == ST_ISSUE || state == ST_BUSY || state == ST_DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_WAIT;
         sd_rd        <= 1'b0;
         sd_address   <= 32'd0;
         grant        <= 1'b0;
         ld_busy      <= 1'b0;
         ld_done      <= 1'b0;
         mus_ptr      <= 32'd0;
         ld_ptr       <= 32'd0;
         ld_cnt       <= 16'd0;
         restart_pend <= 1'b0;
      end else begin
         ld_done <= 1'b0;
         if (ld_req && !ld_busy) begin
            if (ld_blocks == 16'd0) begin
               ld_done <= 1'b1;
            end else begin
               ld_busy <= 1'b1;
               ld_ptr  <= ld_addr;
               ld_cnt  <= ld_blocks;
            end
         end
         if (mus_restart) begin
            if (mus_block) restart_pend <= 1'b1;
            else           mus_ptr      <= mus_start;
         end
         case (state)
            ST_WAIT: if (sd_idle && !sd_reset) state <= ST_ARB;
            ST_ARB: begin
               if (mus_elig || ld_busy) begin
                  grant      <= pick_ld;
                  sd_address <= pick_ld ? ld_ptr : (mus_restart ? mus_start : mus_ptr);
                  sd_rd      <= 1'b1;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (wd_fire) begin
                  sd_rd <= 1'b0;
                  state <= ST_WAIT;
               end else if (!sd_idle) begin
                  sd_rd <= 1'b0;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (wd_fire)      state <= ST_WAIT;
               else if (sd_idle) state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_ARB;
               if (grant) begin
                  ld_ptr <= ld_ptr + 32'd512;
                  ld_cnt <= ld_cnt - 16'd1;
                  if (ld_cnt == 16'd1) begin
                     ld_busy <= 1'b0;
                     ld_done <= 1'b1;
                  end
               end else begin
                  restart_pend <= 1'b0;
                  if (restart_pend || mus_restart || mus_ptr == mus_end) mus_ptr <= mus_start;
                  else                                                    mus_ptr <= mus_ptr + 32'd512;
               end
            end
            default: state <= ST_WAIT;
         endcase
      end
   end

`ifdef SD_SCHED_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic [1:0]      rst_cnt;
   logic            sd_reset_q;
   logic            err_q;

   assign wd_fire = (state == ST_ISSUE || state == ST_BUSY) &&
                    (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt     <= '0;
         rst_cnt    <= 2'd0;
         sd_reset_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (state == ST_ISSUE || state == ST_BUSY) wd_cnt <= wd_cnt + 1'b1;
         else                                       wd_cnt <= '0;
         // Reader reset is held for four cycles: the firing cycle plus three countdown steps.
         if (wd_fire) begin
            sd_reset_q <= 1'b1;
            rst_cnt    <= 2'd3;
            err_q      <= 1'b1;
         end else if (rst_cnt != 2'd0) begin
            rst_cnt <= rst_cnt - 2'd1;
         end else begin
            sd_reset_q <= 1'b0;
         end
      end
   end

   assign sd_reset = sd_reset_q;
   assign err      = err_q;
`else
   assign wd_fire  = 1'b0;
   assign sd_reset = 1'b0;
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_sd_read_sched.sv
// Directed bench for sd_read_sched: arbitration vector table plus loader, restart, reset and watchdog sequences.
module tb_sd_read_sched;

   localparam logic [4:0] IDLE  = 5'd6;
   localparam logic [4:0] BUSYC = 5'd12;
   localparam logic [4:0] BOOT  = 5'd0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  sd_status = BOOT;
   logic        sd_rd;
   logic [31:0] sd_address;
   logic        sd_reset;
   logic [10:0] fifo_usedw = 11'd2000;
   logic        mus_en = 1'b0;
   logic [31:0] mus_start = 32'd0;
   logic [31:0] mus_end = 32'd0;
   logic        mus_restart = 1'b0;
   logic        ld_req = 1'b0;
   logic [31:0] ld_addr = 32'd0;
   logic [15:0] ld_blocks = 16'd0;
   logic        ld_busy;
   logic        ld_done;
   logic        grant;
   logic        err;

   always #5 clk = ~clk;

   sd_read_sched #(
      .SD_IDLE_CODE(6), .LOW_WATER(1024), .URGENT_WATER(256), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sd_status(sd_status), .sd_rd(sd_rd),
      .sd_address(sd_address), .sd_reset(sd_reset), .fifo_usedw(fifo_usedw),
      .mus_en(mus_en), .mus_start(mus_start), .mus_end(mus_end),
      .mus_restart(mus_restart), .ld_req(ld_req), .ld_addr(ld_addr),
      .ld_blocks(ld_blocks), .ld_busy(ld_busy), .ld_done(ld_done),
      .grant(grant), .err(err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ld_done pulse bookkeeping and watchdog-output activity
   int   done_pulses = 0;
   int   done_run = 0;
   int   done_max = 0;
   logic saw_wd = 1'b0;
   always @(negedge clk) begin
      if (ld_done) begin
         done_run++;
         if (done_run == 1) done_pulses++;
         if (done_run > done_max) done_max = done_run;
      end else begin
         done_run = 0;
      end
      if (sd_reset || err) saw_wd = 1'b1;
   end

   task automatic wait_rd(input string name);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (sd_rd) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_rd_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic run_block(input int busy_cycles);
      sd_status = BUSYC;
      repeat (busy_cycles) @(negedge clk);
      chk("rd_dropped", 32'(sd_rd), 32'd0);
      sd_status = IDLE;
   endtask

   task automatic no_rd_for(input string name, input int n);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (sd_rd) seen = 1'b1;
      end
      chk(name, 32'(seen), 32'd0);
   endtask

   typedef struct {
      logic        ld;
      logic [31:0] la;
      logic [15:0] ln;
      logic        men;
      logic [10:0] uw;
      logic [31:0] ea;
      logic        eg;
      logic        eb;
   } vec_t;

   function automatic vec_t mk(input logic ld, input logic [31:0] la, input logic [15:0] ln,
                               input logic men, input logic [10:0] uw, input logic [31:0] ea,
                               input logic eg, input logic eb);
      vec_t v;
      v.ld = ld; v.la = la; v.ln = ln; v.men = men; v.uw = uw; v.ea = ea; v.eg = eg; v.eb = eb;
      return v;
   endfunction

   vec_t tbl [17];

   initial begin
      //            ld  ld_addr      n  men  usedw  exp_addr     g  busy
      tbl[0]  = mk(0, 32'h0,       0, 1, 100,  32'h1000,  0, 0);
      tbl[1]  = mk(0, 32'h0,       0, 1, 100,  32'h1200,  0, 0);
      tbl[2]  = mk(0, 32'h0,       0, 1, 100,  32'h1400,  0, 0);
      tbl[3]  = mk(0, 32'h0,       0, 1, 100,  32'h1000,  0, 0);
      tbl[4]  = mk(1, 32'h8000,    3, 1, 600,  32'h8000,  1, 1);
      tbl[5]  = mk(0, 32'h0,       0, 1, 600,  32'h1200,  0, 1);
      tbl[6]  = mk(0, 32'h0,       0, 1, 600,  32'h8200,  1, 1);
      tbl[7]  = mk(0, 32'h0,       0, 1, 100,  32'h1400,  0, 1);
      tbl[8]  = mk(0, 32'h0,       0, 1, 100,  32'h1000,  0, 1);
      tbl[9]  = mk(0, 32'h0,       0, 1, 300,  32'h8400,  1, 1);
      tbl[10] = mk(0, 32'h0,       0, 1, 300,  32'h1200,  0, 0);
      tbl[11] = mk(1, 32'h20000,   1, 0, 300,  32'h20000, 1, 1);
      tbl[12] = mk(0, 32'h0,       0, 1, 1023, 32'h1400,  0, 0);
      tbl[13] = mk(1, 32'h30000,   2, 1, 255,  32'h1000,  0, 1);
      tbl[14] = mk(0, 32'h0,       0, 1, 256,  32'h30000, 1, 1);
      tbl[15] = mk(0, 32'h0,       0, 1, 256,  32'h1200,  0, 1);
      tbl[16] = mk(0, 32'h0,       0, 0, 256,  32'h30200, 1, 1);

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_sd_rd", 32'(sd_rd), 0);
      chk("rst_addr", sd_address, 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_ld_busy", 32'(ld_busy), 0);
      chk("rst_ld_done", 32'(ld_done), 0);
      chk("rst_sd_reset", 32'(sd_reset), 0);
      chk("rst_err", 32'(err), 0);

      // Card still booting: no read may be issued
      reset_n = 1'b1;
      mus_en = 1'b1;
      fifo_usedw = 11'd100;
      no_rd_for("boot_no_rd", 6);
      mus_en = 1'b0;
      sd_status = IDLE;
      repeat (2) @(negedge clk);

      mus_start = 32'h1000;
      mus_end   = 32'h1400;
      mus_restart = 1'b1;
      @(negedge clk);
      mus_restart = 1'b0;

      for (int i = 0; i < 17; i++) begin
         mus_en = tbl[i].men;
         fifo_usedw = tbl[i].uw;
         if (tbl[i].ld) begin
            ld_addr = tbl[i].la;
            ld_blocks = tbl[i].ln;
            ld_req = 1'b1;
            @(negedge clk);
            ld_req = 1'b0;
         end
         wait_rd($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_addr", i), sd_address, tbl[i].ea);
         chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].eg));
         chk($sformatf("vec%0d_ld_busy", i), 32'(ld_busy), 32'(tbl[i].eb));
         run_block(3);
      end

      // FIFO at LOW_WATER: music not eligible, nothing issued
      mus_en = 1'b1;
      fifo_usedw = 11'd1024;
      no_rd_for("full_fifo_no_rd", 20);
      chk("done_pulses_table", 32'(done_pulses), 32'd3);
      chk("done_width", 32'(done_max), 32'd1);

      // ld_done timing after a single-block job
      mus_en = 1'b0;
      ld_addr = 32'h8000;
      ld_blocks = 16'd1;
      ld_req = 1'b1;
      @(negedge clk);
      ld_req = 1'b0;
      wait_rd("ld1");
      chk("ld1_addr", sd_address, 32'h8000);
      sd_status = BUSYC;
      @(negedge clk);
      sd_status = IDLE;
      @(negedge clk);
      chk("ld1_done_in_DONE", 32'(ld_done), 0);
      chk("ld1_busy_in_DONE", 32'(ld_busy), 1);
      @(negedge clk);
      chk("ld1_done_pulse", 32'(ld_done), 1);
      chk("ld1_busy_clear", 32'(ld_busy), 0);
      @(negedge clk);
      chk("ld1_done_end", 32'(ld_done), 0);

      // Zero-block job: immediate done, never busy, no read
      ld_blocks = 16'd0;
      ld_req = 1'b1;
      @(negedge clk);
      ld_req = 1'b0;
      chk("ld0_done", 32'(ld_done), 1);
      chk("ld0_busy", 32'(ld_busy), 0);
      @(negedge clk);
      chk("ld0_done_end", 32'(ld_done), 0);
      no_rd_for("ld0_no_rd", 10);

      // Request while busy is ignored
      ld_addr = 32'h40000;
      ld_blocks = 16'd2;
      ld_req = 1'b1;
      @(negedge clk);
      ld_req = 1'b0;
      wait_rd("ign_a");
      chk("ign_a_addr", sd_address, 32'h40000);
      sd_status = BUSYC;
      @(negedge clk);
      ld_addr = 32'h50000;
      ld_blocks = 16'd5;
      ld_req = 1'b1;
      @(negedge clk);
      ld_req = 1'b0;
      sd_status = IDLE;
      wait_rd("ign_b");
      chk("ign_b_addr", sd_address, 32'h40200);
      run_block(2);
      no_rd_for("ign_no_third", 20);
      chk("ign_busy_clear", 32'(ld_busy), 0);

      // Restart during a music block at 0x1200
      mus_restart = 1'b1;
      @(negedge clk);
      mus_restart = 1'b0;
      mus_en = 1'b1;
      fifo_usedw = 11'd100;
      wait_rd("rs_a");
      chk("rs_a_addr", sd_address, 32'h1000);
      run_block(2);
      wait_rd("rs_b");
      chk("rs_b_addr", sd_address, 32'h1200);
      sd_status = BUSYC;
      @(negedge clk);
      mus_restart = 1'b1;
      @(negedge clk);
      mus_restart = 1'b0;
      sd_status = IDLE;
      wait_rd("rs_c");
      chk("rs_c_addr", sd_address, 32'h1000);

      // Asynchronous reset mid-BUSY
      sd_status = BUSYC;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst_addr", sd_address, 0);
      chk("arst_sd_rd", 32'(sd_rd), 0);
      chk("arst_grant", 32'(grant), 0);
      chk("arst_ld_busy", 32'(ld_busy), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      sd_status = IDLE;
      wait_rd("post_rst");
      chk("post_rst_addr", sd_address, 32'h0);
      run_block(2);

`ifdef SD_SCHED_WATCHDOG_EN
      begin
         int n;
         int r;
         wait_rd("wd");
         chk("wd_addr", sd_address, 32'h200);
         sd_status = BUSYC;
         n = 0;
         while (n < 1100 && !sd_reset) begin
            @(negedge clk);
            n++;
         end
         chk("wd_fire_cycle", 32'(n), 32'd1000);
         r = 0;
         while (r < 10 && sd_reset) begin
            r++;
            @(negedge clk);
         end
         chk("wd_reset_len", 32'(r), 32'd4);
         chk("wd_err", 32'(err), 1);
         sd_status = IDLE;
         wait_rd("wd_retry");
         chk("wd_retry_addr", sd_address, 32'h200);
         run_block(2);
         chk("wd_err_sticky", 32'(err), 1);
      end
`else
      chk("no_wd_activity", 32'(saw_wd), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
